// File: rtl/pipe_hazard_if.sv
// Pipeline-to-hazard-controller bundle: hazard/memory status in, register enables and perf counters out.
interface pipe_hazard_if #(
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned REG_W = 5;

    logic             idex_memread;
    logic [REG_W-1:0] idex_wn;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ifid_uses_rt;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             en_pc;
    logic             en_ifid;
    logic             en_idex;
    logic             en_exmem;
    logic             en_memwb;
    logic             flush_ifid;
    logic             bubble_idex;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output idex_memread, idex_wn, ifid_rs, ifid_rt, ifid_uses_rt,
               branch_taken, dmem_req, dmem_ready,
        input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, bubble_idex, mem_err, stall_cycles, flush_count
    );

    modport slave (
        input  idex_memread, idex_wn, ifid_rs, ifid_rt, ifid_uses_rt,
               branch_taken, dmem_req, dmem_ready,
        output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, bubble_idex, mem_err, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, branch flushes,
// multi-cycle data-memory waits with a timeout watchdog, and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave bus
);
    localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;

    logic lu_c, mw_c, done_c, issue_c;
    logic en_front_c, en_back_c, flush_c, bubble_c;

    // Hazard detection; register 0 never creates a dependency.
    always_comb begin
        lu_c   = bus.idex_memread && (bus.idex_wn != '0) &&
                 ((bus.idex_wn == bus.ifid_rs) ||
                  (bus.ifid_uses_rt && (bus.idex_wn == bus.ifid_rt)));
        mw_c   = bus.dmem_req && !bus.dmem_ready;
        done_c = bus.dmem_req && bus.dmem_ready;
    end

    // Next state and combinational enables; issue_c means "memory is not holding the pipe".
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        mem_err_d  = mem_err_q;
        issue_c    = 1'b0;
        en_front_c = 1'b0;
        en_back_c  = 1'b0;
        flush_c    = 1'b0;
        bubble_c   = 1'b0;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (mw_c) begin
                        state_d = MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end else begin
                        issue_c = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (done_c) begin
                        issue_c = 1'b1;
                        state_d = RUN;
                        wait_d  = '0;
                    end else if (wait_q >= WAIT_MAX) begin
                        // Abandon the access: release the whole pipe for this cycle.
                        en_front_c = 1'b1;
                        en_back_c  = 1'b1;
                        mem_err_d  = 1'b1;
                        state_d    = RUN;
                        wait_d     = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            endcase

            if (issue_c) begin
                en_back_c  = 1'b1;
                en_front_c = !lu_c;
                bubble_c   = lu_c;
                flush_c    = !lu_c && bus.branch_taken;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!en_front_c && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
        if (flush_c && (flush_q != CNT_MAX))     flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign bus.en_pc        = en_front_c;
    assign bus.en_ifid      = en_front_c;
    assign bus.en_idex      = en_back_c;
    assign bus.en_exmem     = en_back_c;
    assign bus.en_memwb     = en_back_c;
    assign bus.flush_ifid   = flush_c;
    assign bus.bubble_idex  = bubble_c;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int unsigned TO   = 4;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;

    // Expected output vector order: {en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, bubble_idex}
    localparam logic [6:0] V_STALL = 7'b0000000;
    localparam logic [6:0] V_RUN   = 7'b1111100;
    localparam logic [6:0] V_LU    = 7'b0011101;
    localparam logic [6:0] V_BR    = 7'b1111110;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: waiting flag, stall cycles accrued by the current access, sticky error, counters.
    bit m_waiting = 1'b0;
    int m_waited  = 0;
    bit m_err     = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    function automatic bit load_use();
        return bus.idex_memread && (bus.idex_wn != 5'd0) &&
               ((bus.idex_wn == bus.ifid_rs) || (bus.ifid_uses_rt && (bus.idex_wn == bus.ifid_rt)));
    endfunction

    function automatic logic [6:0] predict();
        bit done;
        if (rst) return V_STALL;
        done = bus.dmem_req && bus.dmem_ready;
        if (m_waiting && !done) return (m_waited >= TO) ? V_RUN : V_STALL;
        if (!m_waiting && bus.dmem_req && !bus.dmem_ready) return V_STALL;
        if (load_use()) return V_LU;
        if (bus.branch_taken) return V_BR;
        return V_RUN;
    endfunction

    function automatic logic [6:0] dut_vec();
        return {bus.en_pc, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb,
                bus.flush_ifid, bus.bubble_idex};
    endfunction

    always @(posedge clk) begin
        logic [6:0] p;
        p = predict();
        if (rst) begin
            m_waiting = 1'b0; m_waited = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (!p[6] && m_stall < CMAX) m_stall++;
            if (p[1] && m_flush < CMAX)  m_flush++;
            if (m_waiting) begin
                if (bus.dmem_req && bus.dmem_ready) m_waiting = 1'b0;
                else if (m_waited >= TO) begin m_err = 1'b1; m_waiting = 1'b0; end
                else m_waited++;
            end else if (bus.dmem_req && !bus.dmem_ready) begin
                m_waiting = 1'b1; m_waited = 1;
            end
        end
    end

    task automatic apply(input bit r, input bit mr, input int wn, input int rs, input int rt,
                         input bit urt, input bit br, input bit req, input bit rdy);
        @(negedge clk);
        rst              = r;
        bus.idex_memread = mr;
        bus.idex_wn      = 5'(wn);
        bus.ifid_rs      = 5'(rs);
        bus.ifid_rt      = 5'(rt);
        bus.ifid_uses_rt = urt;
        bus.branch_taken = br;
        bus.dmem_req     = req;
        bus.dmem_ready   = rdy;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 3, 3, 3, 1'b1, 1'b1, 1'b1, 1'(i));
            checks++;
            if (dut_vec() !== V_STALL) begin errors++; $display("FAIL reset_outputs: got %b expected %b", dut_vec(), V_STALL); end
            checks++;
            if (bus.stall_cycles !== 8'd0 || bus.flush_count !== 8'd0 || bus.mem_err !== 1'b0) begin
                errors++; $display("FAIL reset_state: stall=%0d flush=%0d err=%b expected 0 0 0", bus.stall_cycles, bus.flush_count, bus.mem_err);
            end
        end
    endtask

    task automatic test_load_use();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1'b0, 1, 8, 8, 3, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== V_LU) begin errors++; $display("FAIL lu_stall: got %b expected %b", dut_vec(), V_LU); end
        apply(1'b0, 0, 8, 8, 3, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== V_RUN) begin errors++; $display("FAIL lu_release: got %b expected %b", dut_vec(), V_RUN); end
        checks++;
        if (bus.stall_cycles !== 8'd1) begin errors++; $display("FAIL lu_stall_count: got %0d expected 1", bus.stall_cycles); end
        apply(1'b0, 1, 9, 1, 9, 1, 0, 0, 0);
        checks++;
        if (dut_vec() !== V_LU) begin errors++; $display("FAIL lu_rt: got %b expected %b", dut_vec(), V_LU); end
        apply(1'b0, 1, 9, 1, 9, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== V_RUN) begin errors++; $display("FAIL lu_rt_unused: got %b expected %b", dut_vec(), V_RUN); end
    endtask

    task automatic test_zero_reg();
        apply(1'b0, 1, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (dut_vec() !== V_RUN) begin errors++; $display("FAIL zero_reg: got %b expected %b", dut_vec(), V_RUN); end
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (dut_vec() !== V_RUN) begin errors++; $display("FAIL ready_without_req: got %b expected %b", dut_vec(), V_RUN); end
    endtask

    task automatic test_branch_lu();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1'b0, 1, 5, 5, 0, 0, 1, 0, 0);
        checks++;
        if (dut_vec() !== V_LU) begin errors++; $display("FAIL branch_lu_priority: got %b expected %b", dut_vec(), V_LU); end
        apply(1'b0, 0, 5, 5, 0, 0, 1, 0, 0);
        checks++;
        if (dut_vec() !== V_BR) begin errors++; $display("FAIL branch_flush: got %b expected %b", dut_vec(), V_BR); end
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.flush_count !== 8'd1 || bus.stall_cycles !== 8'd1) begin
            errors++; $display("FAIL branch_counts: flush=%0d stall=%0d expected 1 1", bus.flush_count, bus.stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 0, 0, 0, 0, 0, 1, 1, 0);
            checks++;
            if (dut_vec() !== V_STALL) begin errors++; $display("FAIL mem_wait_stall%0d: got %b expected %b", i, dut_vec(), V_STALL); end
        end
        apply(1'b0, 0, 0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (dut_vec() !== V_RUN) begin errors++; $display("FAIL mem_wait_done: got %b expected %b", dut_vec(), V_RUN); end
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== V_RUN || bus.stall_cycles !== 8'd3) begin
            errors++; $display("FAIL mem_wait_after: vec=%b stall=%0d expected %b 3", dut_vec(), bus.stall_cycles, V_RUN);
        end
    endtask

    task automatic test_timeout();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 0, 0, 0, 0, 0, 0, 1, 0);
            checks++;
            if (dut_vec() !== V_STALL || bus.mem_err !== 1'b0) begin
                errors++; $display("FAIL timeout_wait%0d: vec=%b err=%b expected %b 0", i, dut_vec(), bus.mem_err, V_STALL);
            end
        end
        apply(1'b0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (dut_vec() !== V_RUN || bus.mem_err !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: vec=%b err=%b expected %b 0", dut_vec(), bus.mem_err, V_RUN);
        end
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== V_RUN || bus.mem_err !== 1'b1 || bus.stall_cycles !== 8'd4) begin
            errors++; $display("FAIL timeout_after: vec=%b err=%b stall=%0d expected %b 1 4", dut_vec(), bus.mem_err, bus.stall_cycles, V_RUN);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1, 7, 7, 0, 0, 1, 0, 0);
            checks++;
            if (bus.mem_err !== 1'b1) begin errors++; $display("FAIL mem_err_sticky%0d: got %b expected 1", i, bus.mem_err); end
        end
    endtask

    task automatic test_reset_mid_wait();
        apply(1'b0, 0, 0, 0, 0, 0, 0, 1, 0);
        apply(1'b0, 0, 0, 0, 0, 0, 0, 1, 0);
        apply(1'b1, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (dut_vec() !== V_STALL) begin errors++; $display("FAIL rst_mid_wait_outputs: got %b expected %b", dut_vec(), V_STALL); end
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== V_RUN || bus.stall_cycles !== 8'd0 || bus.flush_count !== 8'd0 || bus.mem_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_wait_after: vec=%b stall=%0d flush=%0d err=%b expected %b 0 0 0",
                               dut_vec(), bus.stall_cycles, bus.flush_count, bus.mem_err, V_RUN);
        end
    endtask

    task automatic test_saturation();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) apply(1'b0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.flush_count !== 8'd255) begin errors++; $display("FAIL flush_saturate: got %0d expected 255", bus.flush_count); end
        for (int i = 0; i < 300; i++) apply(1'b0, 1, 2, 2, 0, 0, 0, 0, 0);
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.stall_cycles !== 8'd255 || bus.flush_count !== 8'd255) begin
            errors++; $display("FAIL stall_saturate: stall=%0d flush=%0d expected 255 255", bus.stall_cycles, bus.flush_count);
        end
    endtask

    task automatic test_random();
        logic [6:0] e;
        int bad = 0;
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 99) == 0), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) < 2));
            e = predict();
            checks++;
            if (dut_vec() !== e) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_outputs cyc%0d: got %b expected %b", i, dut_vec(), e);
            end
            checks++;
            if (bus.stall_cycles !== CW'(m_stall) || bus.flush_count !== CW'(m_flush) || bus.mem_err !== m_err) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_state cyc%0d: stall=%0d flush=%0d err=%b expected %0d %0d %b",
                                       i, bus.stall_cycles, bus.flush_count, bus.mem_err, m_stall, m_flush, m_err);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.idex_memread = 1'b0; bus.idex_wn = '0; bus.ifid_rs = '0; bus.ifid_rt = '0;
        bus.ifid_uses_rt = 1'b0; bus.branch_taken = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline CPU. It drives the `en_reg` enable of the PC and of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB), plus the IF_ID flush and the ID_EX bubble-insert controls. Its inputs are load-use hazards, taken branches and a multi-cycle data-memory handshake. It also keeps a watchdog on memory waits and stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before a timeout abort
- CNT_W, 32, width of performance counters (saturating)
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- idex_memread  input  1  instruction in ID_EX is a load
- idex_wn  input  5  destination register of the instruction in ID_EX
- ifid_rs, ifid_rt  input  5 each  source registers of the instruction in IF_ID
- ifid_uses_rt  input  1  instruction in IF_ID reads rt (R-type/store/branch)
- branch_taken  input  1  branch resolved taken in ID this cycle
- dmem_req  input  1  instruction in EX_MEM performs a memory access this cycle
- dmem_ready  input  1  data memory completes the access this cycle
- en_pc, en_ifid, en_idex, en_exmem, en_memwb  output  1 each  register enables
- flush_ifid  output  1  load NOP into IF_ID on next edge
- bubble_idex  output  1  force zero control bits into ID_EX on next edge
- mem_err  output  1  sticky: memory timeout occurred
- stall_cycles, flush_count  output  CNT_W each  performance counters

## Operation
- Two states: RUN, MEM_WAIT. Reset state is RUN.
- Load-use hazard: `lu = idex_memread & (idex_wn != 0) & (idex_wn == ifid_rs | (ifid_uses_rt & idex_wn == ifid_rt))`.
- Memory wait: `mw = dmem_req & ~dmem_ready`.
- Priority when several events coincide: memory wait > load-use > branch.
- RUN with mw=1:
  - All five enables are 0; flush and bubble are 0.
  - Next state is MEM_WAIT; wait counter is set to 1.
- RUN with mw=0 and lu=1:
  - en_pc=0, en_ifid=0, bubble_idex=1.
  - en_idex=en_exmem=en_memwb=1.
  - branch_taken is ignored; the branch re-resolves next cycle.
- RUN with mw=0, lu=0, branch_taken=1: all enables 1, flush_ifid=1.
- RUN, no event: all enables 1, flush and bubble 0.
- MEM_WAIT with dmem_ready=1:
  - Outputs as in RUN with mw=0; lu and branch are evaluated normally this cycle.
  - Next state is RUN.
- MEM_WAIT with dmem_ready=0:
  - All enables 0; wait counter increments.
  - When the counter reaches MEM_TIMEOUT: set mem_err, drive all enables to 1 for that cycle (abandon the access), return to RUN.
- The wait counter must be wide enough for MEM_TIMEOUT. It clears on entry to RUN.
- stall_cycles: +1 on every cycle in which en_pc=0.
- flush_count: +1 on every cycle with flush_ifid=1.
- Both counters saturate at all-ones and never wrap.
- mem_err is cleared only by rst.

## Timing
- All enable/flush/bubble outputs are combinational from the current state and inputs. They act on the same edge at which the pipeline registers sample.
- State, wait counter, mem_err and the performance counters are registered and update on the rising clk edge.
- Load-use costs exactly 1 stall cycle. A taken branch costs exactly 1 flushed slot.
- A memory access taking N cycles of dmem_ready=0 costs N stall cycles, bounded by MEM_TIMEOUT.
- While rst=1:
  - All enables 0; flush_ifid and bubble_idex 0.
  - Next state RUN; wait counter 0; mem_err 0; stall_cycles 0; flush_count 0.
- Reset asserted mid MEM_WAIT returns to RUN on the next edge, with no mem_err and no counter increment.
- dmem_ready=1 while dmem_req=0 is ignored.

## Test plan
- Load-use: idex_memread=1, idex_wn=8, ifid_rs=8 for 1 cycle -> en_pc=en_ifid=0, bubble_idex=1 that cycle; next cycle with idex_memread=0, all enables 1; stall_cycles=1.
- Zero register: idex_memread=1, idex_wn=0, ifid_rs=0 -> no stall; all enables 1, bubble_idex=0.
- Branch + load-use coincide: branch_taken=1 with lu=1 -> flush_ifid=0, bubble_idex=1; next cycle with branch_taken=1 and lu=0 -> flush_ifid=1; flush_count=1.
- Memory wait: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, then all 1; stall_cycles=3; state back to RUN.
- Timeout (MEM_TIMEOUT=4): dmem_ready held 0 -> mem_err rises after the 4th MEM_WAIT cycle, enables all 1 on that cycle, RUN afterwards; mem_err stays 1 until rst.
- Reset during MEM_WAIT: rst=1 on the 2nd wait cycle -> next cycle state RUN, counters 0, mem_err 0, all enables 0 while rst is held.
